// File: rtl/unified_mem_arbiter_pkg.sv
// Shared encodings for the unified BRAM arbiter: FSM states, read-response
// source tags and the address range helper.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IF   = 2'd1,
        SRC_MEM  = 2'd2
    } rsp_src_t;

    // True when a byte address lies beyond the 2**aw-word BRAM.
    function automatic logic addr_oor(input logic [31:0] addr, input int aw);
        return (addr >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Bundle of IF / MEM / loader request paths, status flags and the BRAM port
// seen by the arbiter (slave) and by the pipeline/BRAM side (master).
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_valid;

    logic              ld_mode;
    logic              ld_wr;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_ack;

    logic              stall_if;
    logic              stall_mem;
    logic              core_hold;
    logic              addr_err;

    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;

    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
               ld_mode, ld_wr, ld_addr, ld_wdata, bram_rdata,
        output if_rdata, if_valid, mem_rdata, mem_valid, ld_ack,
               stall_if, stall_mem, core_hold, addr_err,
               bram_en, bram_we, bram_addr, bram_wdata
    );

    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata,
               ld_mode, ld_wr, ld_addr, ld_wdata, bram_rdata,
        input  if_rdata, if_valid, mem_rdata, mem_valid, ld_ack,
               stall_if, stall_mem, core_hold, addr_err,
               bram_en, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter_prio.sv
// IF/MEM grant logic: MEM wins by default, IF is forced through after
// STARVE_LIM consecutive losses.
module mem_arb_prio #(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic if_req,
    input  logic mem_req,
    output logic gnt_if,
    output logic gnt_mem
);
    localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

    logic [CW-1:0] starve_cnt;
    logic          force_if;

    assign force_if = (starve_cnt == CW'(STARVE_LIM));
    assign gnt_if   = en & if_req & (~mem_req | force_if);
    assign gnt_mem  = en & mem_req & ~gnt_if;

    // Only a contested loss counts; the limit check keeps it from wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            starve_cnt <= '0;
        else if (gnt_if)
            starve_cnt <= '0;
        else if (gnt_mem && if_req && !force_if)
            starve_cnt <= starve_cnt + 1'b1;
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port BRAM shared by IF, MEM and the UART loader: RUN/DRAIN/LOAD FSM,
// BRAM request mux and 1-cycle read-response routing.
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    unified_mem_arbiter_if.slave bus
);
    arb_state_t        state, state_nxt;
    rsp_src_t          rsp_src, rsp_src_nxt;
    logic              rsp_zero, rsp_zero_nxt;
    logic              err_q, err_set;
    logic              mem_any, if_oor, mem_oor, gnt_if, gnt_mem;
    logic              en, we, ack, stl_if, stl_mem, hold;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    assign mem_any = bus.mem_rd | bus.mem_wr;
    assign if_oor  = addr_oor(bus.if_addr, ADDR_W);
    assign mem_oor = addr_oor(bus.mem_addr, ADDR_W);

    mem_arb_prio #(.STARVE_LIM(STARVE_LIM)) u_prio (
        .clk     (clk),
        .rst     (rst),
        .en      (state == ST_RUN),
        .if_req  (bus.if_req),
        .mem_req (mem_any),
        .gnt_if  (gnt_if),
        .gnt_mem (gnt_mem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            rsp_src  <= SRC_NONE;
            rsp_zero <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rsp_src  <= rsp_src_nxt;
            rsp_zero <= rsp_zero_nxt;
            err_q    <= err_q | err_set;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN:   if (bus.ld_mode) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_LOAD;
            ST_LOAD:  if (!bus.ld_mode) state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // Out-of-range requests still take their grant slot but skip the BRAM
    // and return zero data.
    always_comb begin
        en           = 1'b0;
        we           = 1'b0;
        ack          = 1'b0;
        stl_if       = 1'b0;
        stl_mem      = 1'b0;
        hold         = 1'b0;
        addr         = '0;
        wdata        = '0;
        err_set      = 1'b0;
        rsp_src_nxt  = SRC_NONE;
        rsp_zero_nxt = 1'b0;
        if (rst) begin
            unique case (state)
                ST_RUN: begin
                    stl_if  = bus.if_req & ~gnt_if;
                    stl_mem = mem_any & ~gnt_mem;
                    err_set = (bus.if_req & if_oor) | (mem_any & mem_oor) |
                              (bus.mem_rd & bus.mem_wr);
                    if (gnt_mem) begin
                        en    = ~mem_oor;
                        we    = bus.mem_wr & ~mem_oor;
                        addr  = bus.mem_addr[ADDR_W+1:2];
                        wdata = bus.mem_wdata;
                        if (!bus.mem_wr) begin
                            rsp_src_nxt  = SRC_MEM;
                            rsp_zero_nxt = mem_oor;
                        end
                    end else if (gnt_if) begin
                        en           = ~if_oor;
                        addr         = bus.if_addr[ADDR_W+1:2];
                        rsp_src_nxt  = SRC_IF;
                        rsp_zero_nxt = if_oor;
                    end
                end
                ST_DRAIN: begin
                    stl_if  = 1'b1;
                    stl_mem = 1'b1;
                    hold    = 1'b1;
                end
                default: begin
                    stl_if  = 1'b1;
                    stl_mem = 1'b1;
                    hold    = 1'b1;
                    en      = bus.ld_wr;
                    we      = bus.ld_wr;
                    ack     = bus.ld_wr;
                    addr    = bus.ld_addr;
                    wdata   = bus.ld_wdata;
                end
            endcase
        end
    end

    assign bus.bram_en    = en;
    assign bus.bram_we    = we;
    assign bus.bram_addr  = addr;
    assign bus.bram_wdata = wdata;
    assign bus.ld_ack     = ack;
    assign bus.stall_if   = stl_if;
    assign bus.stall_mem  = stl_mem;
    assign bus.core_hold  = hold;
    assign bus.addr_err   = err_q;
    assign bus.if_valid   = (rsp_src == SRC_IF);
    assign bus.mem_valid  = (rsp_src == SRC_MEM);
    assign bus.if_rdata   = (rsp_src == SRC_IF  && !rsp_zero) ? bus.bram_rdata : '0;
    assign bus.mem_rdata  = (rsp_src == SRC_MEM && !rsp_zero) ? bus.bram_rdata : '0;

endmodule
